// File: rtl/id_stage_pipe.sv
// Instruction decode stage: register file with WB bypass, opcode decode, load-use bubbles, flush, sticky halt.
// Latency: one cycle from accepted instr to the ID/EX register outputs.
// Backpressure: id_ready drops on halt, load-use hazard, flush or a full ID/EX register with ex_ready low.

// Opcode decoder: maps instr[31:26] to the control bundle; unknown opcodes decode to all-zero controls.
module decoder (
   input  logic [5:0] opcode,
   output logic       writeRd,
   output logic       ldic,
   output logic       isSignEx,
   output logic       immed,
   output logic [3:0] alu_ctrl,
   output logic       isJump,
   output logic       isJR,
   output logic       rs_read,
   output logic       rt_read,
   output logic       mem_ren,
   output logic       mem_wen,
   output logic       lw,
   output logic       link,
   output logic       reg_wen,
   output logic       halt,
   output logic       strcnt,
   output logic       stpcnt,
   output logic       inc_instr
);
   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_JR     = 6'h06;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_LDIC   = 6'h0F;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;
   localparam logic [5:0] OP_STRCNT = 6'h30;
   localparam logic [5:0] OP_STPCNT = 6'h31;
   localparam logic [5:0] OP_HALT   = 6'h3F;

   // Per-opcode control table; ALU op for R-type is refined from funct in EX.
   always_comb begin
      writeRd   = 1'b0;
      ldic      = 1'b0;
      isSignEx  = 1'b0;
      immed     = 1'b0;
      alu_ctrl  = 4'h0;
      isJump    = 1'b0;
      isJR      = 1'b0;
      rs_read   = 1'b0;
      rt_read   = 1'b0;
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
      lw        = 1'b0;
      link      = 1'b0;
      reg_wen   = 1'b0;
      halt      = 1'b0;
      strcnt    = 1'b0;
      stpcnt    = 1'b0;
      inc_instr = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            writeRd = 1'b1; rs_read = 1'b1; rt_read = 1'b1; reg_wen = 1'b1; inc_instr = 1'b1;
         end
         OP_ADDI: begin
            isSignEx = 1'b1; immed = 1'b1; alu_ctrl = 4'h1; rs_read = 1'b1;
            reg_wen = 1'b1; inc_instr = 1'b1;
         end
         OP_LW: begin
            isSignEx = 1'b1; immed = 1'b1; alu_ctrl = 4'h1; rs_read = 1'b1; mem_ren = 1'b1;
            lw = 1'b1; reg_wen = 1'b1; inc_instr = 1'b1;
         end
         OP_SW: begin
            isSignEx = 1'b1; immed = 1'b1; alu_ctrl = 4'h1; rs_read = 1'b1; rt_read = 1'b1;
            mem_wen = 1'b1; inc_instr = 1'b1;
         end
         OP_J: begin
            isJump = 1'b1; inc_instr = 1'b1;
         end
         OP_JAL: begin
            isJump = 1'b1; link = 1'b1; reg_wen = 1'b1; inc_instr = 1'b1;
         end
         OP_JR: begin
            isJR = 1'b1; rs_read = 1'b1; inc_instr = 1'b1;
         end
         OP_LDIC: begin
            ldic = 1'b1; immed = 1'b1; alu_ctrl = 4'h4; reg_wen = 1'b1; inc_instr = 1'b1;
         end
         OP_STRCNT: begin
            strcnt = 1'b1; inc_instr = 1'b1;
         end
         OP_STPCNT: begin
            stpcnt = 1'b1; inc_instr = 1'b1;
         end
         OP_HALT: begin
            halt = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

module id_stage_pipe #(
   parameter int DATA_W   = 32,
   parameter int NREG     = 32,
   parameter int LINK_REG = NREG - 1,
   localparam int AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instr,
   input  logic              instr_valid,
   output logic              id_ready,
   input  logic              flush,
   input  logic              reg_wen_wb,
   input  logic [AW-1:0]     waddr_wb,
   input  logic [DATA_W-1:0] wdata_wb,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic [AW-1:0]     rs_idx,
   output logic [AW-1:0]     rt_idx,
   output logic [AW-1:0]     dst_idx,
   output logic [22:0]       ctrl,
   output logic              halted
);
   localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);

   // ctrl bit positions used by the hazard check
   localparam int C_LW      = 14;
   localparam int C_REG_WEN = 16;

   logic [DATA_W-1:0] regs [NREG];

   logic [AW-1:0]     rs_a, rt_a, rd_a, dst_nxt;
   logic [DATA_W-1:0] rs_rd, rt_rd;
   logic [22:0]       dec_ctrl;
   logic              hazard, slot_free, accept;
   logic              unused_bits;

   logic       d_writeRd, d_ldic, d_isSignEx, d_immed;
   logic [3:0] d_alu_ctrl;
   logic       d_isJump, d_isJR, d_rs_read, d_rt_read, d_mem_ren, d_mem_wen;
   logic       d_lw, d_link, d_reg_wen, d_halt, d_strcnt, d_stpcnt, d_inc_instr;

   assign rs_a = instr[21 +: AW];
   assign rt_a = instr[16 +: AW];
   assign rd_a = instr[11 +: AW];

   // Immediate/funct bits and unused high index bits are consumed downstream, not here.
   assign unused_bits = ^{instr[10:0], instr[25:11]};

   decoder u_decoder (
      .opcode    (instr[31:26]),
      .writeRd   (d_writeRd),
      .ldic      (d_ldic),
      .isSignEx  (d_isSignEx),
      .immed     (d_immed),
      .alu_ctrl  (d_alu_ctrl),
      .isJump    (d_isJump),
      .isJR      (d_isJR),
      .rs_read   (d_rs_read),
      .rt_read   (d_rt_read),
      .mem_ren   (d_mem_ren),
      .mem_wen   (d_mem_wen),
      .lw        (d_lw),
      .link      (d_link),
      .reg_wen   (d_reg_wen),
      .halt      (d_halt),
      .strcnt    (d_strcnt),
      .stpcnt    (d_stpcnt),
      .inc_instr (d_inc_instr)
   );

   assign dec_ctrl = {2'b00, d_inc_instr, d_stpcnt, d_strcnt, d_halt, d_reg_wen, d_link, d_lw,
                      d_mem_wen, d_mem_ren, d_rt_read, d_rs_read, d_isJR, d_isJump,
                      d_alu_ctrl, d_immed, d_isSignEx, d_ldic, d_writeRd};

   // Destination select: rd for R-type, link register for calls, rt otherwise.
   always_comb begin
      dst_nxt = rt_a;
      if (d_writeRd)   dst_nxt = rd_a;
      else if (d_link) dst_nxt = LINK_IDX;
   end

   // Operand read with r0 hardwired to zero and same-cycle WB write-through.
   always_comb begin
      rs_rd = '0;
      rt_rd = '0;
      if (rs_a != '0) begin
         if (reg_wen_wb && waddr_wb == rs_a) rs_rd = wdata_wb;
         else                                rs_rd = regs[rs_a];
      end
      if (rt_a != '0) begin
         if (reg_wen_wb && waddr_wb == rt_a) rt_rd = wdata_wb;
         else                                rt_rd = regs[rt_a];
      end
   end

   // Load-use: a load in ID/EX whose result is a source of the incoming instruction.
   always_comb begin
      hazard = ex_valid && ctrl[C_LW] && ctrl[C_REG_WEN] && (dst_idx != '0) &&
               ((d_rs_read && rs_a == dst_idx) || (d_rt_read && rt_a == dst_idx));
   end

   assign slot_free = !ex_valid || ex_ready;
   assign id_ready  = rst_n && !halted && !hazard && !flush && slot_free;
   assign accept    = instr_valid && id_ready;

   // Register file write port; r0 is never written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (reg_wen_wb && waddr_wb != '0) begin
         regs[waddr_wb] <= wdata_wb;
      end
   end

   // ID/EX register: flush beats accept beats bubble beats drain; otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
         ctrl     <= '0;
         rs_data  <= '0;
         rt_data  <= '0;
         rs_idx   <= '0;
         rt_idx   <= '0;
         dst_idx  <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
         ctrl     <= '0;
      end else if (accept) begin
         ex_valid <= 1'b1;
         ctrl     <= dec_ctrl;
         rs_data  <= rs_rd;
         rt_data  <= rt_rd;
         rs_idx   <= rs_a;
         rt_idx   <= rt_a;
         dst_idx  <= dst_nxt;
      end else if (hazard && slot_free) begin
         ex_valid <= 1'b0;
         ctrl     <= '0;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

   // Sticky halt: set when a halt instruction is accepted, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                halted <= 1'b0;
      else if (accept && d_halt) halted <= 1'b1;
   end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: scoreboard of expected ID/EX contents built from a register-file shadow.
// Latency: expectations are pushed when an instr is driven and popped one edge later.
// Backpressure: stall, bubble, flush and halt cases drive ex_ready/flush directly.
module tb_id_stage_pipe;
   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_JR = 6'h06;
   localparam logic [5:0] OP_ADDI = 6'h08, OP_LDIC = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] OP_STRCNT = 6'h30, OP_STPCNT = 6'h31, OP_HALT = 6'h3F;

   typedef struct packed {
      logic [31:0] rs_d;
      logic [31:0] rt_d;
      logic [4:0]  rs_i;
      logic [4:0]  rt_i;
      logic [4:0]  dst_i;
      logic [22:0] c;
   } exp_t;

   logic        clk, rst_n;
   logic [31:0] instr;
   logic        instr_valid, id_ready, flush, reg_wen_wb, ex_valid, ex_ready, halted;
   logic [4:0]  waddr_wb, rs_idx, rt_idx, dst_idx;
   logic [31:0] wdata_wb, rs_data, rt_data;
   logic [22:0] ctrl;

   exp_t        sb[$];
   logic [31:0] model_rf [32];
   logic        rdy_seen;
   int          checks = 0;
   int          errors = 0;

   id_stage_pipe #(.DATA_W(32), .NREG(32), .LINK_REG(31)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .id_ready(id_ready),
      .flush(flush), .reg_wen_wb(reg_wen_wb), .waddr_wb(waddr_wb), .wdata_wb(wdata_wb),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .rs_data(rs_data), .rt_data(rt_data),
      .rs_idx(rs_idx), .rt_idx(rt_idx), .dst_idx(dst_idx), .ctrl(ctrl), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd);
      return {op, rs, rt, rd, 11'h0};
   endfunction

   // Reference control bundle for each opcode, bit positions as listed for ctrl.
   function automatic logic [22:0] exp_ctrl(input logic [5:0] op);
      logic [22:0] c;
      c = '0;
      case (op)
         OP_R:      begin c[0] = 1; c[10] = 1; c[11] = 1; c[16] = 1; c[20] = 1; end
         OP_ADDI:   begin c[2] = 1; c[3] = 1; c[7:4] = 4'h1; c[10] = 1; c[16] = 1; c[20] = 1; end
         OP_LW:     begin c[2] = 1; c[3] = 1; c[7:4] = 4'h1; c[10] = 1; c[12] = 1; c[14] = 1;
                          c[16] = 1; c[20] = 1; end
         OP_SW:     begin c[2] = 1; c[3] = 1; c[7:4] = 4'h1; c[10] = 1; c[11] = 1; c[13] = 1;
                          c[20] = 1; end
         OP_J:      begin c[8] = 1; c[20] = 1; end
         OP_JAL:    begin c[8] = 1; c[15] = 1; c[16] = 1; c[20] = 1; end
         OP_JR:     begin c[9] = 1; c[10] = 1; c[20] = 1; end
         OP_LDIC:   begin c[1] = 1; c[3] = 1; c[7:4] = 4'h4; c[16] = 1; c[20] = 1; end
         OP_STRCNT: begin c[18] = 1; c[20] = 1; end
         OP_STPCNT: begin c[19] = 1; c[20] = 1; end
         OP_HALT:   c[17] = 1;
         default:   c = '0;
      endcase
      return c;
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] r);
      if (r == 5'd0) return 32'h0;
      if (reg_wen_wb && waddr_wb == r) return wdata_wb;
      return model_rf[r];
   endfunction

   function automatic exp_t make_exp(input logic [31:0] ins);
      exp_t e;
      e.c     = exp_ctrl(ins[31:26]);
      e.rs_i  = ins[25:21];
      e.rt_i  = ins[20:16];
      e.dst_i = e.c[0] ? ins[15:11] : (e.c[15] ? 5'd31 : ins[20:16]);
      e.rs_d  = model_read(ins[25:21]);
      e.rt_d  = model_read(ins[20:16]);
      return e;
   endfunction

   function automatic exp_t obs();
      return {rs_data, rt_data, rs_idx, rt_idx, dst_idx, ctrl};
   endfunction

   // One clock of stimulus; records id_ready mid-cycle and leaves outputs settled after the edge.
   task automatic cycle(input logic [31:0] ins, input logic iv, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic fl, input logic er, input logic exp_acc);
      instr = ins; instr_valid = iv; reg_wen_wb = we; waddr_wb = wa; wdata_wb = wd;
      flush = fl; ex_ready = er;
      if (exp_acc) sb.push_back(make_exp(ins));
      @(negedge clk);
      rdy_seen = id_ready;
      @(posedge clk);
      if (we && wa != 5'd0) model_rf[wa] = wd;
      #1;
      instr_valid = 0; reg_wen_wb = 0; flush = 0; ex_ready = 1;
   endtask

   task automatic test_reset();
      rst_n = 0; instr = mk(OP_R, 1, 2, 3); instr_valid = 1; flush = 0; ex_ready = 1;
      reg_wen_wb = 0; waddr_wb = 0; wdata_wb = 0;
      for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
      #12;
      checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL reset_id_ready: got %b want 0", id_ready); end
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
      checks++; if (obs() !== exp_t'(0)) begin errors++; $display("FAIL reset_outputs: got %h want 0", obs()); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
      instr_valid = 0;
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   task automatic test_wb_read();
      exp_t e;
      cycle(32'h0, 0, 1, 5'd5, 32'h1234_5678, 0, 1, 0);
      cycle(mk(OP_R, 5, 0, 9), 1, 0, 0, 0, 0, 1, 1);
      checks++; if (rdy_seen !== 1'b1) begin errors++; $display("FAIL wb_read_ready: got %b want 1", rdy_seen); end
      e = sb.pop_front();
      checks++; if (obs() !== e || ex_valid !== 1'b1) begin errors++; $display("FAIL wb_read_issue: got %h v=%b want %h v=1", obs(), ex_valid, e); end
      checks++; if (rs_data !== 32'h1234_5678 || rt_data !== 32'h0) begin errors++; $display("FAIL wb_read_data: got %h/%h want 12345678/0", rs_data, rt_data); end
      cycle(32'h0, 0, 0, 0, 0, 0, 1, 0);
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL wb_read_drain: got %b want 0", ex_valid); end
   endtask

   task automatic test_bypass();
      exp_t e;
      cycle(mk(OP_ADDI, 7, 2, 0), 1, 1, 5'd7, 32'hA5, 0, 1, 1);
      e = sb.pop_front();
      checks++; if (obs() !== e || rs_data !== 32'hA5) begin errors++; $display("FAIL bypass_same_cycle: got %h want %h", obs(), e); end
      cycle(mk(OP_R, 0, 7, 3), 1, 1, 5'd0, 32'hFF, 0, 1, 1);
      e = sb.pop_front();
      checks++; if (obs() !== e || rs_data !== 32'h0) begin errors++; $display("FAIL bypass_r0_write: got %h want %h", obs(), e); end
      cycle(mk(OP_R, 0, 0, 4), 1, 0, 0, 0, 0, 1, 1);
      e = sb.pop_front();
      checks++; if (obs() !== e || rs_data !== 32'h0) begin errors++; $display("FAIL bypass_r0_read: got %h want %h", obs(), e); end
   endtask

   task automatic test_load_use();
      exp_t e;
      // rs dependency
      cycle(mk(OP_LW, 5, 3, 0), 1, 0, 0, 0, 0, 1, 1);
      e = sb.pop_front();
      checks++; if (obs() !== e || ex_valid !== 1'b1) begin errors++; $display("FAIL lu_load_issue: got %h want %h", obs(), e); end
      cycle(mk(OP_R, 3, 4, 6), 1, 0, 0, 0, 0, 1, 0);
      checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL lu_rs_stall: id_ready %b want 0", rdy_seen); end
      checks++; if (ex_valid !== 1'b0 || ctrl !== 23'h0) begin errors++; $display("FAIL lu_bubble: v=%b ctrl=%h want 0/0", ex_valid, ctrl); end
      cycle(mk(OP_R, 3, 4, 6), 1, 0, 0, 0, 0, 1, 1);
      checks++; if (rdy_seen !== 1'b1) begin errors++; $display("FAIL lu_rs_retry: id_ready %b want 1", rdy_seen); end
      e = sb.pop_front();
      checks++; if (obs() !== e || ex_valid !== 1'b1) begin errors++; $display("FAIL lu_rs_issue: got %h want %h", obs(), e); end
      // independent source: no stall
      cycle(mk(OP_LW, 5, 3, 0), 1, 0, 0, 0, 0, 1, 1);
      void'(sb.pop_front());
      cycle(mk(OP_ADDI, 4, 6, 0), 1, 0, 0, 0, 0, 1, 1);
      checks++; if (rdy_seen !== 1'b1) begin errors++; $display("FAIL lu_indep: id_ready %b want 1", rdy_seen); end
      e = sb.pop_front();
      checks++; if (obs() !== e) begin errors++; $display("FAIL lu_indep_issue: got %h want %h", obs(), e); end
      // rt dependency
      cycle(mk(OP_LW, 5, 3, 0), 1, 0, 0, 0, 0, 1, 1);
      void'(sb.pop_front());
      cycle(mk(OP_SW, 4, 3, 0), 1, 0, 0, 0, 0, 1, 0);
      checks++; if (rdy_seen !== 1'b0 || ex_valid !== 1'b0) begin errors++; $display("FAIL lu_rt_stall: rdy=%b v=%b want 0/0", rdy_seen, ex_valid); end
      cycle(mk(OP_SW, 4, 3, 0), 1, 0, 0, 0, 0, 1, 1);
      e = sb.pop_front();
      checks++; if (obs() !== e || rdy_seen !== 1'b1) begin errors++; $display("FAIL lu_rt_issue: got %h want %h", obs(), e); end
      // load to r0 never stalls
      cycle(mk(OP_LW, 5, 0, 0), 1, 0, 0, 0, 0, 1, 1);
      void'(sb.pop_front());
      cycle(mk(OP_R, 0, 0, 2), 1, 0, 0, 0, 0, 1, 1);
      e = sb.pop_front();
      checks++; if (obs() !== e || rdy_seen !== 1'b1) begin errors++; $display("FAIL lu_r0: got %h rdy=%b want %h", obs(), rdy_seen, e); end
   endtask

   task automatic test_backpressure();
      exp_t e, hold;
      cycle(mk(OP_ADDI, 5, 8, 0), 1, 0, 0, 0, 0, 1, 1);
      hold = sb.pop_front();
      checks++; if (obs() !== hold) begin errors++; $display("FAIL bp_first: got %h want %h", obs(), hold); end
      for (int i = 0; i < 3; i++) begin
         cycle(mk(OP_R, 5, 5, 10), 1, 0, 0, 0, 0, 0, 0);
         checks++; if (rdy_seen !== 1'b0 || ex_valid !== 1'b1 || obs() !== hold) begin
            errors++; $display("FAIL bp_hold%0d: rdy=%b v=%b got %h want %h", i, rdy_seen, ex_valid, obs(), hold);
         end
      end
      cycle(mk(OP_R, 5, 5, 10), 1, 0, 0, 0, 0, 1, 1);
      e = sb.pop_front();
      checks++; if (rdy_seen !== 1'b1 || obs() !== e) begin errors++; $display("FAIL bp_release: rdy=%b got %h want %h", rdy_seen, obs(), e); end
   endtask

   task automatic test_flush();
      cycle(mk(OP_ADDI, 1, 2, 0), 1, 0, 0, 0, 1, 1, 0);
      checks++; if (rdy_seen !== 1'b0 || ex_valid !== 1'b0 || ctrl !== 23'h0) begin
         errors++; $display("FAIL flush_kill: rdy=%b v=%b ctrl=%h want 0/0/0", rdy_seen, ex_valid, ctrl);
      end
      cycle(32'h0, 0, 0, 0, 0, 0, 1, 0);
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept: v=%b want 0", ex_valid); end
      cycle(mk(OP_R, 1, 2, 3), 1, 0, 0, 0, 0, 1, 1);
      void'(sb.pop_front());
      cycle(mk(OP_ADDI, 1, 2, 0), 1, 0, 0, 0, 1, 0, 0);
      checks++; if (ex_valid !== 1'b0 || ctrl !== 23'h0) begin errors++; $display("FAIL flush_stalled: v=%b ctrl=%h want 0/0", ex_valid, ctrl); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] prog [9];
      exp_t e;
      prog = '{mk(OP_R, 1, 2, 3), mk(OP_JAL, 0, 0, 0), mk(OP_LDIC, 0, 12, 0), mk(OP_SW, 3, 4, 0),
               mk(OP_STRCNT, 1, 1, 0), mk(OP_J, 2, 3, 0), mk(OP_STPCNT, 4, 2, 0), mk(OP_JR, 2, 1, 0),
               mk(6'h15, 3, 9, 7)};
      for (int i = 1; i <= 4; i++) cycle(32'h0, 0, 1, 5'(i), $urandom, 0, 1, 0);
      for (int i = 0; i < 9; i++) begin
         cycle(prog[i], 1, 1, 5'($urandom_range(1, 4)), $urandom, 0, 1, 1);
         e = sb.pop_front();
         checks++; if (rdy_seen !== 1'b1 || ex_valid !== 1'b1 || obs() !== e) begin
            errors++; $display("FAIL b2b_%0d: rdy=%b v=%b got %h want %h", i, rdy_seen, ex_valid, obs(), e);
         end
      end
   endtask

   task automatic test_halt();
      exp_t e;
      cycle(mk(OP_HALT, 0, 0, 0), 1, 0, 0, 0, 0, 1, 1);
      e = sb.pop_front();
      checks++; if (obs() !== e || ex_valid !== 1'b1 || halted !== 1'b1) begin
         errors++; $display("FAIL halt_issue: got %h v=%b h=%b want %h v=1 h=1", obs(), ex_valid, halted, e);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(mk(OP_R, 1, 2, 3), 1, 0, 0, 0, 0, 1, 0);
         checks++; if (rdy_seen !== 1'b0 || ex_valid !== 1'b0) begin
            errors++; $display("FAIL halt_block%0d: rdy=%b v=%b want 0/0", i, rdy_seen, ex_valid);
         end
      end
      cycle(32'h0, 0, 0, 0, 0, 1, 1, 0);
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flush: halted=%b want 1", halted); end
      rst_n = 0;
      for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
      @(negedge clk);
      checks++; if (halted !== 1'b0 || id_ready !== 1'b0) begin errors++; $display("FAIL halt_reset: h=%b rdy=%b want 0/0", halted, id_ready); end
      instr = mk(OP_R, 5, 0, 1); instr_valid = 1; ex_ready = 1;
      sb.push_back(make_exp(instr));
      #1 rst_n = 1;
      @(posedge clk); #1;
      instr_valid = 0;
      e = sb.pop_front();
      checks++; if (ex_valid !== 1'b1 || obs() !== e || rs_data !== 32'h0) begin
         errors++; $display("FAIL halt_first_accept: v=%b got %h want %h", ex_valid, obs(), e);
      end
   endtask

   initial begin
      test_reset();
      test_wb_read();
      test_bypass();
      test_load_use();
      test_backpressure();
      test_flush();
      test_back_to_back();
      test_halt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
